// File: rtl/rotator_shift_reg.sv
// Parametrised shift/rotate register with a valid/ready command interface.
// Multi-step shift/rotate commands advance one bit per clock and can be paused with stall.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a command; single-edge ops (LOAD/CLEAR/NOP) finish here
// RUN   | executing latched shift/rotate op, one step per unstalled edge
module rotator_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             stall,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_ROL   = 3'b010;
    localparam logic [2:0] OP_ROR   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [AMT_W-1:0]   cnt;
    logic [WIDTH-1:0]   step_q;
    logic               step_sout;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);

    // One-bit move for the latched op; sin is sampled live on every step edge.
    always_comb begin
        step_q    = q;
        step_sout = sout;
        case (op_q)
            OP_ROL: begin
                step_q    = {q[WIDTH-2:0], q[WIDTH-1]};
                step_sout = q[WIDTH-1];
            end
            OP_ROR: begin
                step_q    = {q[0], q[WIDTH-1:1]};
                step_sout = q[0];
            end
            OP_SHL: begin
                step_q    = {q[WIDTH-2:0], sin};
                step_sout = q[WIDTH-1];
            end
            OP_SHR: begin
                step_q    = {sin, q[WIDTH-1:1]};
                step_sout = q[0];
            end
            OP_ASR: begin
                step_q    = {q[WIDTH-1], q[WIDTH-1:1]};
                step_sout = q[0];
            end
            default: begin
                step_q    = q;
                step_sout = sout;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            op_q  <= OP_NOP;
            cnt   <= '0;
            q     <= '0;
            sout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_NOP: begin
                                done <= 1'b1;
                            end
                            OP_LOAD: begin
                                q    <= d;
                                done <= 1'b1;
                            end
                            OP_CLEAR: begin
                                q    <= '0;
                                done <= 1'b1;
                            end
                            default: begin
                                // Zero-length shift/rotate completes like a NOP.
                                if (cmd_amt == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    op_q  <= cmd_op;
                                    cnt   <= cmd_amt;
                                    state <= RUN;
                                end
                            end
                        endcase
                    end
                end
                RUN: begin
                    if (!stall) begin
                        q    <= step_q;
                        sout <= step_sout;
                        cnt  <= cnt - 1'b1;
                        if (cnt == AMT_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotator_shift_reg.sv
// Directed bench for rotator_shift_reg (WIDTH=8, AMT_W=3) with a result scoreboard.
// Expected command results come from a behavioural model and are popped on each done pulse.
module tb_rotator_shift_reg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_ROL   = 3'b010;
    localparam logic [2:0] OP_ROR   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_amt;
    logic [7:0] d;
    logic       sin;
    logic       stall;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] q;
        logic       sout;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_q;
    logic       m_sout;
    int         n_checks;
    int         n_fail;

    rotator_shift_reg #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .d         (d),
        .sin       (sin),
        .stall     (stall),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: one bit move, returns {sout, q}.
    function automatic logic [8:0] mstep(input logic [2:0] op, input logic [7:0] v, input logic s);
        case (op)
            OP_ROL:  return {v[7], v[6:0], v[7]};
            OP_ROR:  return {v[0], v[0], v[7:1]};
            OP_SHL:  return {v[7], v[6:0], s};
            OP_SHR:  return {v[0], s, v[7:1]};
            OP_ASR:  return {v[0], v[7], v[7:1]};
            default: return {1'b0, v};
        endcase
    endfunction

    // Drive one command across its accept edge and record the expected final result.
    task automatic issue(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data,
                         input logic s_in, input bit push);
        logic [8:0] r;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        d         = data;
        sin       = s_in;
        if (op == OP_LOAD) begin
            m_q = data;
        end else if (op == OP_CLEAR) begin
            m_q = 8'h00;
        end else if (op != OP_NOP) begin
            for (int i = 0; i < int'(amt); i++) begin
                r      = mstep(op, m_q, s_in);
                m_q    = r[7:0];
                m_sout = r[8];
            end
        end
        if (push) sb.push_back('{q: m_q, sout: m_sout});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_q"}, 32'(q), 32'(e.q));
            chk({tag, "_sout"}, 32'(sout), 32'(e.sout));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_q       = 8'h00;
        m_sout    = 1'b0;
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_amt   = 3'd0;
        d         = 8'hFF;
        sin       = 1'b0;
        stall     = 1'b0;

        // Reset with a LOAD pending: must be ignored.
        tick();
        tick();
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_sout", 32'(sout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        tick();
        chk("post_rst_q", 32'(q), 32'h00);

        issue(OP_LOAD, 3'd0, 8'hA5, 1'b0, 1'b1);
        chk("load_a5_q", 32'(q), 32'hA5);
        sb_check("load_a5");
        tick();
        chk("load_a5_done_once", 32'(done), 32'd0);
        issue(OP_NOP, 3'd0, 8'h3C, 1'b0, 1'b1);
        sb_check("nop");
        chk("nop_q", 32'(q), 32'hA5);
        tick();
        chk("nop_done_once", 32'(done), 32'd0);

        // ROL 3 with a LOAD attempted while busy.
        issue(OP_LOAD, 3'd0, 8'h96, 1'b0, 1'b1);
        sb_check("load_96");
        issue(OP_ROL, 3'd3, 8'h00, 1'b0, 1'b1);
        chk("rol_accept_q", 32'(q), 32'h96);
        chk("rol_busy", 32'(busy), 32'd1);
        chk("rol_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        d         = 8'hFF;
        tick();
        chk("rol_s1", 32'(q), 32'h2D);
        cmd_valid = 1'b0;
        tick();
        chk("rol_s2", 32'(q), 32'h5A);
        chk("rol_s2_done", 32'(done), 32'd0);
        tick();
        chk("rol_s3", 32'(q), 32'hB4);
        sb_check("rol3");
        chk("rol3_sout", 32'(sout), 32'd0);
        tick();
        chk("rol3_idle", 32'(busy), 32'd0);
        chk("rol3_done_once", 32'(done), 32'd0);

        // ASR then back-to-back SHR with sin=1.
        issue(OP_LOAD, 3'd0, 8'h90, 1'b0, 1'b1);
        sb_check("load_90");
        issue(OP_ASR, 3'd2, 8'h00, 1'b0, 1'b1);
        tick();
        chk("asr_s1", 32'(q), 32'hC8);
        tick();
        chk("asr_s2", 32'(q), 32'hE4);
        sb_check("asr2");
        chk("asr2_ready_at_done", 32'(cmd_ready), 32'd1);
        issue(OP_LOAD, 3'd0, 8'h0F, 1'b0, 1'b1);
        sb_check("load_0f");
        issue(OP_SHR, 3'd4, 8'h00, 1'b1, 1'b1);
        tick();
        chk("shr_s1", 32'(q), 32'h87);
        tick();
        chk("shr_s2", 32'(q), 32'hC3);
        tick();
        chk("shr_s3", 32'(q), 32'hE1);
        tick();
        chk("shr_s4", 32'(q), 32'hF0);
        sb_check("shr4");
        chk("shr4_sout", 32'(sout), 32'd1);

        issue(OP_SHL, 3'd2, 8'h00, 1'b0, 1'b1);
        tick();
        chk("shl_s1", 32'(q), 32'hE0);
        tick();
        sb_check("shl2");

        // Zero-length rotate behaves as NOP.
        issue(OP_ROL, 3'd0, 8'h00, 1'b0, 1'b1);
        sb_check("rol0");
        chk("rol0_busy", 32'(busy), 32'd0);

        // ROR 4 with a two-cycle stall after the second step.
        issue(OP_LOAD, 3'd0, 8'h81, 1'b0, 1'b1);
        sb_check("load_81");
        issue(OP_ROR, 3'd4, 8'h00, 1'b0, 1'b1);
        tick();
        chk("ror_s1", 32'(q), 32'hC0);
        chk("ror_s1_sout", 32'(sout), 32'd1);
        tick();
        chk("ror_s2", 32'(q), 32'h60);
        stall = 1'b1;
        tick();
        chk("ror_hold1", 32'(q), 32'h60);
        chk("ror_hold1_busy", 32'(busy), 32'd1);
        chk("ror_hold1_done", 32'(done), 32'd0);
        tick();
        chk("ror_hold2", 32'(q), 32'h60);
        chk("ror_hold2_sout", 32'(sout), 32'd0);
        stall = 1'b0;
        tick();
        chk("ror_s3", 32'(q), 32'h30);
        chk("ror_s3_done", 32'(done), 32'd0);
        tick();
        chk("ror_s4", 32'(q), 32'h18);
        sb_check("ror4");

        // Reset aborts a running ROL 7 with no done pulse.
        issue(OP_LOAD, 3'd0, 8'h01, 1'b0, 1'b1);
        sb_check("load_01");
        issue(OP_ROL, 3'd7, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk("abort_pre_q", 32'(q), 32'h08);
        reset = 1'b0;
        tick();
        m_q    = 8'h00;
        m_sout = 1'b0;
        chk("abort_q", 32'(q), 32'h00);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sout", 32'(sout), 32'd0);
        reset = 1'b1;
        tick();
        chk("abort_release_ready", 32'(cmd_ready), 32'd1);
        chk("abort_release_done", 32'(done), 32'd0);
        chk("abort_release_q", 32'(q), 32'h00);
        issue(OP_CLEAR, 3'd0, 8'hFF, 1'b0, 1'b1);
        sb_check("clear");
        tick();
        chk("clear_done_once", 32'(done), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rotator_shift_reg.md
Name: rotator_shift_reg

Overview:
- Parametrised successor to the 4-bit cyclic parallel-load shift register.
- Generic WIDTH; eight operations: load, clear, rotate left/right, logical shift left/right with serial fill, arithmetic shift right.
- Shift/rotate commands run for a programmable number of steps, one bit per clock, under a valid/ready command handshake with busy/done status.
- Sits in Sequential/ as a reusable datapath element for serialisers, barrel-rotate emulation and test pattern generators.

Parameters:
- WIDTH, 8, register width in bits; legal values are 2 and above.
- AMT_W, 3, width of the step-count field; maximum steps per command is 2^AMT_W-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high iff state==IDLE.
- cmd_op  input  3  opcode: 000 NOP, 001 LOAD, 010 ROL, 011 ROR, 100 SHL, 101 SHR, 110 ASR, 111 CLEAR.
- cmd_amt  input  AMT_W  number of 1-bit steps for opcodes 010-110.
- d  input  WIDTH  parallel load data, sampled at accept for LOAD.
- sin  input  1  serial fill bit for SHL/SHR, sampled on each step edge.
- stall  input  1  freezes a running operation while high.
- q  output  WIDTH  register contents.
- sout  output  1  bit shifted/rotated out on the most recent step.
- busy  output  1  high iff state==RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset==0 at posedge): q=0, sout=0, done=0, counter=0, state=IDLE. Any command presented in the same cycle is ignored. Reset overrides everything, including a mid-RUN operation, which is aborted with no done pulse.
- Accept means cmd_valid && cmd_ready at a posedge. Commands presented while busy are ignored; no queueing.
- States: IDLE and RUN.
- LOAD: q<=d at the accept edge; done=1 for the next cycle; stay IDLE.
- CLEAR: q<=0 at the accept edge; done=1 for the next cycle; stay IDLE.
- NOP: q unchanged; done=1 for the next cycle; stay IDLE.
- Opcodes 010-110 with cmd_amt==0: same as NOP.
- Opcodes 010-110 with cmd_amt=N>0:
  - At the accept edge: latch op, counter<=N, go to RUN. q is unchanged at this edge.
  - In RUN with stall==0: each posedge performs one step and decrements counter.
  - On the step where counter==1: go to IDLE and set done=1 for the following cycle.
  - Result: final q is visible N edges after the accept edge, together with done.
  - In RUN with stall==1: q, counter and sout hold.
- Step definitions (W=WIDTH):
  - ROL: q<={q[W-2:0],q[W-1]}; sout<=q[W-1].
  - ROR: q<={q[0],q[W-1:1]}; sout<=q[0].
  - SHL: q<={q[W-2:0],sin}; sout<=q[W-1].
  - SHR: q<={sin,q[W-1:1]}; sout<=q[0].
  - ASR: q<={q[W-1],q[W-1:1]}; sout<=q[0].
- sout changes only on step edges and holds between them.
- done is registered; it is high for exactly one cycle per completed command and is 0 at all other times.
- stall is ignored in IDLE.
- Back-to-back commands: the cycle that shows done also has cmd_ready=1, so a new command may be accepted at that edge.
- Arithmetic is 1-bit moves only; no overflow condition exists. The counter is AMT_W bits wide and never wraps below 0.

Test Plan (WIDTH=8, AMT_W=3):
- Hold reset low 2 cycles with cmd_valid=1 LOAD d=FF -> q=00, sout=0, busy=0, done=0, cmd_ready=1; the load is ignored.
- LOAD d=A5 -> q=A5 on the next cycle with done=1 for that cycle only. Then NOP -> q stays A5, done pulses.
- LOAD 96, then ROL amt=3 -> q steps 2D, 5A, B4 on 3 successive edges. busy is high for 3 cycles, done coincides with q=B4, sout=0. A LOAD issued during busy is ignored.
- LOAD 90, ASR amt=2 -> q=C8, then E4; sout=0. Then LOAD 0F, SHR amt=4 with sin=1 -> q=87, C3, E1, F0; final sout=1.
- LOAD 81, ROR amt=4 with stall=1 for 2 cycles after the 2nd step -> q=C0, 60, held for 2 cycles, then 30, 18. done arrives 6 edges after accept.
- ROL amt=7 from 01, drop reset after 3 steps -> q=00, busy=0, no done pulse, cmd_ready=1 after reset is released. A following CLEAR pulses done with q=00.
